// File: rtl/codec_intf.sv
// codec_intf: codec pin sequencer; derives MCLK/SCL/LRCLK/RSTn from one
// 10-bit timebase and converts the left-justified serial stream to/from
// parallel 16-bit left/right samples with a one-cycle vld strobe.
//
// Ports:
//   clk, RST_n          system clock, async active-low reset
//   RSTn                codec reset (low until first edge after RST_n release)
//   MCLK, SCL, LRCLK    codec clocks (clk/4, clk/32, clk/1024; LRCLK high=left)
//   SDout / SDin        serial ADC data in / serial DAC data out
//   lft_in, rht_in, vld last received sample pair and its publish strobe
//   lft_out, rht_out    sample pair to transmit, sampled at cnt==0x3FF
module codec_intf #(
  parameter int unsigned WARMUP_FRAMES = 2
) (
  input  logic        clk,
  input  logic        RST_n,
  output logic        RSTn,
  output logic        MCLK,
  output logic        SCL,
  output logic        LRCLK,
  input  logic        SDout,
  output logic        SDin,
  output logic [15:0] lft_in,
  output logic [15:0] rht_in,
  output logic        vld,
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out
);

  localparam logic [3:0] WARM = 4'(WARMUP_FRAMES);

  logic [9:0]  cnt;
  logic [15:0] rx_sh;
  logic [15:0] shadow;
  logic [15:0] rx_nxt;
  logic [31:0] tx_sh;
  logic [3:0]  frm;
  logic        warm;
  logic        rx_tick;
  logic        tx_tick;

  // Codec clocks come straight off counter flops: no decode glitches.
  assign MCLK  = cnt[1];
  assign SCL   = cnt[4];
  assign LRCLK = ~cnt[9];
  assign SDin  = tx_sh[31];

  assign rx_nxt  = {rx_sh[14:0], SDout};
  assign rx_tick = (cnt[4:0] == 5'd15);
  assign tx_tick = (cnt[4:0] == 5'd31);
  assign warm    = (frm == WARM);

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      RSTn   <= 1'b0;
      cnt    <= '0;
      rx_sh  <= '0;
      shadow <= '0;
      tx_sh  <= '0;
      frm    <= '0;
      lft_in <= '0;
      rht_in <= '0;
      vld    <= 1'b0;
    end else begin
      RSTn <= 1'b1;
      vld  <= 1'b0;
      // Timebase stays parked at 0 until the codec is out of reset.
      if (RSTn)
        cnt <= cnt + 10'd1;
      if (rx_tick)
        rx_sh <= rx_nxt;
      // Left word completes mid-frame; hold it until right completes.
      if (cnt == 10'h1EF)
        shadow <= rx_nxt;
      if (cnt == 10'h3EF && warm) begin
        lft_in <= shadow;
        rht_in <= rx_nxt;
        vld    <= 1'b1;
      end
      if (cnt == 10'h3FF) begin
        tx_sh <= {lft_out, rht_out};
        if (!warm)
          frm <= frm + 4'd1;
      end else if (tx_tick) begin
        tx_sh <= {tx_sh[30:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_codec_intf.sv
// tb_codec_intf: directed bench for codec_intf (default and WARMUP_FRAMES=1)
// against a cycle timebase model; all checks go through chk.
module tb_codec_intf;

  logic        clk = 1'b0;
  logic        RST_n;
  logic        SDout;
  logic [15:0] lft_out, rht_out;

  logic        RSTn, MCLK, SCL, LRCLK, SDin, vld;
  logic [15:0] lft_in, rht_in;
  logic        RSTn1, MCLK1, SCL1, LRCLK1, SDin1, vld1;
  logic [15:0] lft_in1, rht_in1;

  logic        loop;
  logic [15:0] tx_l, tx_r;
  logic [15:0] pat_l, pat_r;

  logic [9:0]  mcnt;
  logic        mrun;
  int          frame;
  logic [15:0] exp_l, exp_r, exp1_l, exp1_r;
  logic [31:0] txcur, txasm;
  int          cyc;
  int          fv0, fv1;
  logic        track;

  int ntests = 0;
  int nfail  = 0;

  always #10 clk = ~clk;

  assign lft_out = loop ? lft_in : tx_l;
  assign rht_out = loop ? rht_in : tx_r;

  codec_intf u_dut (
    .clk(clk), .RST_n(RST_n), .RSTn(RSTn),
    .MCLK(MCLK), .SCL(SCL), .LRCLK(LRCLK),
    .SDout(SDout), .SDin(SDin),
    .lft_in(lft_in), .rht_in(rht_in), .vld(vld),
    .lft_out(lft_out), .rht_out(rht_out)
  );

  codec_intf #(.WARMUP_FRAMES(1)) u_w1 (
    .clk(clk), .RST_n(RST_n), .RSTn(RSTn1),
    .MCLK(MCLK1), .SCL(SCL1), .LRCLK(LRCLK1),
    .SDout(SDout), .SDin(SDin1),
    .lft_in(lft_in1), .rht_in(rht_in1), .vld(vld1),
    .lft_out(lft_out), .rht_out(rht_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [31:0] ld;
    logic        ev0, ev1;
    int          s;
    ld = loop ? {exp_l, exp_r} : {tx_l, tx_r};
    @(posedge clk);
    #1;
    cyc++;
    if (!RST_n) begin
      mrun = 1'b0; mcnt = '0; frame = 0;
      exp_l = '0; exp_r = '0; exp1_l = '0; exp1_r = '0;
      txcur = '0; txasm = '0;
    end else begin
      if (mrun) begin
        if (mcnt == 10'h3FF) begin
          txcur = ld;
          frame++;
        end
        mcnt = mcnt + 10'd1;
      end
      mrun = 1'b1;
    end
    s = int'(mcnt[9:5]);
    SDout = (s < 16) ? pat_l[15-s] : pat_r[31-s];
    ev0 = (mcnt == 10'h3F0) && (frame >= 2);
    ev1 = (mcnt == 10'h3F0) && (frame >= 1);
    if (ev0) begin exp_l = pat_l; exp_r = pat_r; end
    if (ev1) begin exp1_l = pat_l; exp1_r = pat_r; end
    chk("RSTn", RSTn, mrun);
    chk("MCLK", MCLK, mcnt[1]);
    chk("SCL", SCL, mcnt[4]);
    chk("LRCLK", LRCLK, !mcnt[9]);
    chk("SDin", SDin, txcur[31-s]);
    chk("vld", vld, ev0);
    chk("lft_in", lft_in, exp_l);
    chk("rht_in", rht_in, exp_r);
    chk("w1_SDin", SDin1, txcur[31-s]);
    chk("w1_vld", vld1, ev1);
    chk("w1_lft_in", lft_in1, exp1_l);
    chk("w1_rht_in", rht_in1, exp1_r);
    if (mcnt[4:0] == 5'd16)
      txasm[31-s] = SDin;
    if (mcnt == 10'h3F0)
      chk("tx_word", txasm, txcur);
    if (track && vld && fv0 < 0) fv0 = cyc;
    if (track && vld1 && fv1 < 0) fv1 = cyc;
  endtask

  task automatic run_to(input logic [9:0] target);
    for (int i = 0; i < 1100 && mcnt != target; i++)
      tick();
  endtask

  initial begin
    RST_n = 1'b0; SDout = 1'b0; loop = 1'b0;
    tx_l = 16'h8001; tx_r = 16'h7FFE;
    pat_l = 16'hA5C3; pat_r = 16'h0F01;
    mcnt = '0; mrun = 1'b0; frame = 0; cyc = 0;
    exp_l = '0; exp_r = '0; exp1_l = '0; exp1_r = '0;
    txcur = '0; txasm = '0;
    fv0 = -1; fv1 = -1; track = 1'b1;

    repeat (10) tick();
    RST_n = 1'b1;
    repeat (4*1024 + 2) tick();
    chk("w1_first_vld_lead", 32'(fv0 - fv1), 32'd1024);
    track = 1'b0;

    loop = 1'b1;
    run_to(10'h3FF);
    pat_l = 16'h1234; pat_r = 16'hFEDC;
    repeat (3*1024) tick();

    run_to(10'h155);
    #4;
    RST_n = 1'b0;
    #1;
    chk("async_RSTn", RSTn, 1'b0);
    chk("async_MCLK", MCLK, 1'b0);
    chk("async_SCL", SCL, 1'b0);
    chk("async_LRCLK", LRCLK, 1'b1);
    chk("async_SDin", SDin, 1'b0);
    chk("async_vld", vld, 1'b0);
    chk("async_lft_in", lft_in, 16'h0);
    chk("async_rht_in", rht_in, 16'h0);
    chk("async_w1_lft_in", lft_in1, 16'h0);
    pat_l = 16'h5A5A; pat_r = 16'hC33C;
    repeat (3) tick();
    RST_n = 1'b1;
    repeat (4*1024 + 2) tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
